// File: rtl/lp_pkg.sv
// Shared types for the loop sequencer and its attached LoopCounter.
package lp_pkg;

    // Control bundle consumed by LoopCounter; bit order {dval, inc, reset}.
    typedef struct packed {
        logic dval;
        logic inc;
        logic reset;
    } LpCtl;

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} LpSeqState;

    localparam LpCtl LpCtlNone  = '{dval: 1'b0, inc: 1'b0, reset: 1'b0};
    localparam LpCtl LpCtlReset = '{dval: 1'b1, inc: 1'b0, reset: 1'b1};
    localparam LpCtl LpCtlStep  = '{dval: 1'b1, inc: 1'b1, reset: 1'b0};

endpackage

// File: rtl/lp_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module lp_sat_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [Width-1:0] o_cnt
);

    logic [Width-1:0] cntQ, cntD;

    always_comb begin
        cntD = cntQ;
        if (i_clr) begin
            cntD = '0;
        end else if (i_en && !(&cntQ)) begin
            cntD = cntQ + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign o_cnt = cntQ;

endmodule

// File: rtl/loop_sequencer.sv
// Turns a start pulse into handshaken loop iterations driving an external LoopCounter.
// Optional stall counter (o_stallCnt) is built when LPSEQ_STALL_CNT_EN is defined.
module loop_sequencer
    import lp_pkg::*;
#(
    parameter int unsigned NDepth  = 3,
    parameter int unsigned StallDW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [NDepth-1:0] i_loopEnd,
    output LpCtl              o_ctl,
    output logic              o_val,
    input  logic              i_rdy,
    output logic [NDepth-1:0] o_end,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
`ifdef LPSEQ_STALL_CNT_EN
    ,
    output logic [StallDW-1:0] o_stallCnt
`endif
);

    if (NDepth < 1 || StallDW < 1) begin : gParamCheck
        $error("loop_sequencer: NDepth and StallDW must be at least 1");
    end

    LpSeqState stateQ, stateD;
    logic      allEnd;
    logic      inRun;

    assign allEnd = &i_loopEnd;
    assign inRun  = (stateQ == RUN);

    always_comb begin
        stateD = stateQ;
        o_ctl  = LpCtlNone;
        o_done = 1'b0;
        unique case (stateQ)
            IDLE: begin
                // Abort wins over a simultaneous start.
                if (i_start && !i_abort) begin
                    stateD = INIT;
                end
            end
            INIT: begin
                o_ctl  = LpCtlReset;
                stateD = i_abort ? IDLE : RUN;
            end
            RUN: begin
                if (i_abort) begin
                    o_ctl  = LpCtlReset;
                    stateD = IDLE;
                end else if (i_rdy) begin
                    // Counter steps on this edge; it wraps itself to all-1 after the last one.
                    o_ctl = LpCtlStep;
                    if (allEnd) begin
                        stateD = DONE;
                    end
                end
            end
            DONE: begin
                if (i_abort) begin
                    o_ctl = LpCtlReset;
                end else begin
                    o_done = 1'b1;
                end
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    assign o_val  = inRun && !i_abort;
    assign o_busy = (stateQ != IDLE);
    assign o_end  = o_val ? i_loopEnd : '0;
    assign o_last = o_val && allEnd;

`ifdef LPSEQ_STALL_CNT_EN
    lp_sat_cnt #(
        .Width (StallDW)
    ) uStallCnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (stateQ == INIT),
        .i_en  (o_val && !i_rdy),
        .o_cnt (o_stallCnt)
    );
`endif

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer with a behavioural nested-loop counter alongside.
module tb_loop_sequencer;
    import lp_pkg::*;

    localparam int unsigned NDepth  = 3;
    localparam int unsigned StallDW = 16;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              rdy   = 1'b1;
    logic [NDepth-1:0] loopEnd;
    logic [NDepth-1:0] oEnd;
    LpCtl              ctl;
    logic [2:0]        ctlBits;
    logic              val, last, busy, done;
`ifdef LPSEQ_STALL_CNT_EN
    logic [StallDW-1:0] stallCnt;
`endif

    int sizes[NDepth];
    int idx[NDepth];
    int nCmp = 0;
    int nErr = 0;
    int hsCnt, incCnt, badInc, lastCnt, lastHs, doneCnt, valCycles;
    bit seen;

    always #5 clk = ~clk;

    assign ctlBits = ctl;

    loop_sequencer #(
        .NDepth  (NDepth),
        .StallDW (StallDW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_loopEnd  (loopEnd),
        .o_ctl      (ctl),
        .o_val      (val),
        .i_rdy      (rdy),
        .o_end      (oEnd),
        .o_last     (last),
        .o_busy     (busy),
        .o_done     (done)
`ifdef LPSEQ_STALL_CNT_EN
        ,
        .o_stallCnt (stallCnt)
`endif
    );

    // Reference odometer: indices run 1..size, innermost level 0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NDepth; i++) idx[i] <= 1;
        end else if (ctl.dval) begin
            if (ctl.reset) begin
                for (int i = 0; i < NDepth; i++) idx[i] <= 1;
            end else if (ctl.inc) begin
                automatic bit carry = 1'b1;
                for (int i = 0; i < NDepth; i++) begin
                    if (carry) begin
                        if (idx[i] == sizes[i]) begin
                            idx[i] <= 1;
                        end else begin
                            idx[i] <= idx[i] + 1;
                            carry = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        loopEnd = '0;
        for (int i = 0; i < NDepth; i++) loopEnd[i] = (idx[i] == sizes[i]);
    end

    always @(posedge clk) begin
        if (last) begin
            lastCnt++;
            lastHs = hsCnt;
        end
        if (val) valCycles++;
        if (ctl.inc) begin
            incCnt++;
            if (!(val && rdy)) badInc++;
        end
        if (val && rdy) hsCnt++;
        if (done) doneCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp)
        else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearStats();
        hsCnt = 0; incCnt = 0; badInc = 0; lastCnt = 0;
        lastHs = -1; doneCnt = 0; valCycles = 0;
    endtask

    task automatic setSizes(input int s0, input int s1, input int s2);
        sizes[0] = s0; sizes[1] = s1; sizes[2] = s2;
    endtask

    // Returns in the INIT cycle, just after the falling edge.
    task automatic doStart();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // mode 0: rdy held high; mode 1: rdy toggles 1,0,1,... over RUN cycles.
    task automatic waitDone(input int mode, input int budget, output bit found);
        bit tog = 1'b1;
        found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            rdy = (mode == 0) ? 1'b1 : tog;
            #1;
            if (val) tog = ~tog;
            if (done) found = 1'b1;
        end
        if (!found) $error("FAIL waitDone: observed timeout expected o_done within %0d", budget);
    endtask

    task automatic waitHs(input int n, input int budget);
        for (int c = 0; c < budget && hsCnt < n; c++) @(negedge clk);
        check("waitHs", 32'(hsCnt), 32'(n));
    endtask

    initial begin
        setSizes(2, 3, 2);
        clearStats();

        // Reset state
        #3;
        check("rst_ctl", 32'(ctlBits), 32'h0);
        check("rst_val", 32'(val), 32'h0);
        check("rst_end", 32'(oEnd), 32'h0);
        check("rst_last", 32'(last), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
`ifdef LPSEQ_STALL_CNT_EN
        check("rst_stall", 32'(stallCnt), 32'h0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Sizes {2,3,2}, rdy held high
        clearStats();
        doStart();
        #1;
        check("init_busy", 32'(busy), 32'h1);
        check("init_ctl", 32'(ctlBits), 32'h5);
        check("init_val", 32'(val), 32'h0);
        @(negedge clk); #1;
        check("run_first_val", 32'(val), 32'h1);
        check("run_first_ctl", 32'(ctlBits), 32'h6);
        waitDone(0, 60, seen);
        check("t1_done_seen", 32'(seen), 32'h1);
        check("t1_hs", 32'(hsCnt), 32'd12);
        check("t1_valCycles", 32'(valCycles), 32'd12);
        check("t1_lastCnt", 32'(lastCnt), 32'd1);
        check("t1_lastHs", 32'(lastHs), 32'd11);
        check("t1_inc", 32'(incCnt), 32'd12);
        check("t1_idx0", 32'(idx[0]), 32'd1);
        check("t1_idx1", 32'(idx[1]), 32'd1);
        check("t1_idx2", 32'(idx[2]), 32'd1);
        @(negedge clk); #1;
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_done_pulse", 32'(done), 32'h0);
        check("t1_doneCnt", 32'(doneCnt), 32'd1);

        // Same sizes, rdy toggling
        clearStats();
        doStart();
        waitDone(1, 80, seen);
        check("t2_done_seen", 32'(seen), 32'h1);
        check("t2_hs", 32'(hsCnt), 32'd12);
        check("t2_inc", 32'(incCnt), 32'd12);
        check("t2_badInc", 32'(badInc), 32'd0);
        check("t2_valCycles", 32'(valCycles), 32'd23);
`ifdef LPSEQ_STALL_CNT_EN
        check("t2_stall", 32'(stallCnt), 32'd11);
`endif
        @(negedge clk); #1;
        check("t2_idle_busy", 32'(busy), 32'h0);
`ifdef LPSEQ_STALL_CNT_EN
        check("t2_stall_hold", 32'(stallCnt), 32'd11);
`endif
        rdy = 1'b1;

        // Sizes {1,1,1}
        setSizes(1, 1, 1);
        clearStats();
        doStart();
        @(negedge clk); #1;
        check("t3_val", 32'(val), 32'h1);
        check("t3_last", 32'(last), 32'h1);
        check("t3_end", 32'(oEnd), 32'h7);
        waitDone(0, 10, seen);
        check("t3_done_seen", 32'(seen), 32'h1);
        check("t3_hs", 32'(hsCnt), 32'd1);
        check("t3_valCycles", 32'(valCycles), 32'd1);

        // Abort after the 5th handshake
        setSizes(2, 3, 2);
        @(negedge clk);
        clearStats();
        doStart();
        waitHs(5, 30);
        abort = 1'b1;
        #1;
        check("t4_abort_ctl", 32'(ctlBits), 32'h5);
        check("t4_abort_val", 32'(val), 32'h0);
        check("t4_abort_last", 32'(last), 32'h0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("t4_idle_busy", 32'(busy), 32'h0);
        check("t4_hs", 32'(hsCnt), 32'd5);
        check("t4_doneCnt", 32'(doneCnt), 32'd0);
        clearStats();
        doStart();
        waitDone(0, 60, seen);
        check("t4_restart_done", 32'(seen), 32'h1);
        check("t4_restart_hs", 32'(hsCnt), 32'd12);

        // Start during RUN ignored; start+abort in IDLE ignored
        @(negedge clk);
        clearStats();
        doStart();
        waitHs(3, 30);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(0, 60, seen);
        check("t5_done_seen", 32'(seen), 32'h1);
        check("t5_hs", 32'(hsCnt), 32'd12);
        @(negedge clk); #1;
        check("t5_doneCnt", 32'(doneCnt), 32'd1);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("t5_sa_busy", 32'(busy), 32'h0);
        @(negedge clk); #1;
        check("t5_sa_busy2", 32'(busy), 32'h0);
        check("t5_sa_ctl", 32'(ctlBits), 32'h0);

        // Asynchronous reset mid-RUN
        clearStats();
        doStart();
        waitHs(4, 30);
        #2;
        rst = 1'b1;
        #1;
        check("t6_val", 32'(val), 32'h0);
        check("t6_ctl", 32'(ctlBits), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_end", 32'(oEnd), 32'h0);
        check("t6_last", 32'(last), 32'h0);
        check("t6_done", 32'(done), 32'h0);
`ifdef LPSEQ_STALL_CNT_EN
        check("t6_stall", 32'(stallCnt), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("t6_idle_busy", 32'(busy), 32'h0);
        check("t6_idle_val", 32'(val), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
